// File: rtl/traffic_intersection_ctrl.sv
// N-approach intersection controller: round-robin green/yellow/all-red phases,
// per-approach pedestrian requests and a byte-command lamp override.
module traffic_intersection_ctrl #(
    parameter int unsigned N_APP    = 3,
    parameter int unsigned CLK_HZ   = 12000000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned GREEN_T  = 5000,
    parameter int unsigned YELLOW_T = 2000,
    parameter int unsigned ALLRED_T = 1000,
    parameter int unsigned PED_EXT  = 3000,
    localparam int unsigned SEL_W   = $clog2(N_APP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_APP-1:0] ped_req,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_data,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic [N_APP-1:0] red,
    output logic [N_APP-1:0] yellow,
    output logic [N_APP-1:0] green,
    output logic [SEL_W-1:0] active_idx,
    output logic             override_active,
    output logic [N_APP-1:0] ped_pending
);

    localparam int unsigned PRE_TC = CLK_HZ / TICK_HZ - 1;
    localparam int unsigned PRE_W  = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;
    localparam int unsigned GE_T   = GREEN_T + PED_EXT;
    localparam int unsigned YA_MAX = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
    localparam int unsigned T_MAX  = (GE_T > YA_MAX) ? GE_T : YA_MAX;
    localparam int unsigned TMR_W  = $clog2(T_MAX + 1);
    localparam bit          EXT_EN = (PED_EXT != 0);

    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] CMD_Y = 8'h59;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_X = 8'h58;

    typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_OVERRIDE} state_t;
    typedef enum logic [1:0] {C_RED, C_YELLOW, C_GREEN} colour_t;

    state_t             state;
    colour_t            ov_colour;
    logic [TMR_W-1:0]   timer;
    logic [PRE_W-1:0]   pre_cnt;
    logic [N_APP-1:0]   ped_prev;
    logic               ext_used;

    logic               tick;
    logic               expiry;
    logic [N_APP-1:0]   ped_rise;
    logic               sel_ok;
    logic               colour_ok;
    logic               cmd_set;
    logic               cmd_release;
    colour_t            cmd_colour;
    logic               ext_req;
    logic               green_entry;
    logic [SEL_W-1:0]   next_idx;
    logic [N_APP-1:0]   pend_next;
    colour_t            lamp_colour;
    logic [N_APP-1:0]   red_next;
    logic [N_APP-1:0]   yellow_next;
    logic [N_APP-1:0]   green_next;

    // Free-running tick prescaler, independent of the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_W'(PRE_TC)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign tick     = (pre_cnt == PRE_W'(PRE_TC));
    assign expiry   = tick && (timer == '0);
    assign ped_rise = ped_req & ~ped_prev;

    always_comb begin
        sel_ok     = (32'(cmd_sel) < N_APP);
        colour_ok  = 1'b1;
        cmd_colour = C_RED;
        case (cmd_data)
            CMD_G:   cmd_colour = C_GREEN;
            CMD_Y:   cmd_colour = C_YELLOW;
            CMD_R:   cmd_colour = C_RED;
            default: colour_ok = 1'b0;
        endcase
        cmd_set     = cmd_valid && sel_ok && colour_ok;
        cmd_release = cmd_valid && sel_ok && (cmd_data == CMD_X) && (state == S_OVERRIDE);
    end

    always_comb begin
        next_idx    = (active_idx == SEL_W'(N_APP - 1)) ? '0 : active_idx + SEL_W'(1);
        ext_req     = EXT_EN && (state == S_GREEN) && ped_rise[active_idx] && !ext_used;
        green_entry = !cmd_set && !cmd_release && (state == S_ALL_RED) && expiry;
        pend_next   = ped_pending | ped_rise;
        // A press on the approach currently green extends (or is dropped), never pends
        if (state == S_GREEN) begin
            pend_next[active_idx] = ped_pending[active_idx];
        end
        if (green_entry) begin
            pend_next[next_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_ALL_RED;
            timer           <= TMR_W'(ALLRED_T - 1);
            active_idx      <= SEL_W'(N_APP - 1);
            ov_colour       <= C_RED;
            ext_used        <= 1'b0;
            override_active <= 1'b0;
            ped_pending     <= '0;
            ped_prev        <= '0;
        end else begin
            ped_prev    <= ped_req;
            ped_pending <= pend_next;
            if (cmd_set) begin
                state           <= S_OVERRIDE;
                active_idx      <= cmd_sel;
                ov_colour       <= cmd_colour;
                override_active <= 1'b1;
            end else if (cmd_release) begin
                state           <= S_ALL_RED;
                timer           <= TMR_W'(ALLRED_T - 1);
                active_idx      <= cmd_sel;
                override_active <= 1'b0;
            end else begin
                case (state)
                    S_ALL_RED: begin
                        if (expiry) begin
                            state      <= S_GREEN;
                            timer      <= TMR_W'(GREEN_T - 1);
                            active_idx <= next_idx;
                            ext_used   <= 1'b0;
                        end else if (tick) begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    S_GREEN: begin
                        if (ext_req) begin
                            timer    <= timer + TMR_W'(PED_EXT) - TMR_W'(tick);
                            ext_used <= 1'b1;
                        end else if (expiry) begin
                            state <= S_YELLOW;
                            timer <= TMR_W'(YELLOW_T - 1);
                        end else if (tick) begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    S_YELLOW: begin
                        if (expiry) begin
                            state <= S_ALL_RED;
                            timer <= TMR_W'(ALLRED_T - 1);
                        end else if (tick) begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Lamp pattern for the current state; registered one cycle behind the FSM
    always_comb begin
        red_next    = '1;
        yellow_next = '0;
        green_next  = '0;
        case (state)
            S_GREEN:    lamp_colour = C_GREEN;
            S_YELLOW:   lamp_colour = C_YELLOW;
            S_OVERRIDE: lamp_colour = ov_colour;
            default:    lamp_colour = C_RED;
        endcase
        if (lamp_colour == C_GREEN) begin
            red_next[active_idx]   = 1'b0;
            green_next[active_idx] = 1'b1;
        end else if (lamp_colour == C_YELLOW) begin
            red_next[active_idx]    = 1'b0;
            yellow_next[active_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red    <= '1;
            yellow <= '0;
            green  <= '0;
        end else begin
            red    <= red_next;
            yellow <= yellow_next;
            green  <= green_next;
        end
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl: phase sequence, pedestrian
// extension/pending, command override, invalid commands and mid-phase reset.
module tb_traffic_intersection_ctrl;

    localparam logic [8:0] P_AR = 9'b111_000_000;
    localparam logic [8:0] P_G0 = 9'b110_000_001;
    localparam logic [8:0] P_Y0 = 9'b110_001_000;
    localparam logic [8:0] P_G1 = 9'b101_000_010;
    localparam logic [8:0] P_Y1 = 9'b101_010_000;
    localparam logic [8:0] P_G2 = 9'b011_000_100;
    localparam logic [8:0] P_Y2 = 9'b011_100_000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ped_req;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic [1:0] cmd_sel;
    logic [2:0] red;
    logic [2:0] yellow;
    logic [2:0] green;
    logic [1:0] active_idx;
    logic       override_active;
    logic [2:0] ped_pending;
    logic [8:0] lamps;

    int total = 0;
    int bad   = 0;
    int len;

    assign lamps = {red, yellow, green};

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .N_APP(3), .CLK_HZ(100), .TICK_HZ(10), .GREEN_T(4),
        .YELLOW_T(2), .ALLRED_T(1), .PED_EXT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .cmd_valid(cmd_valid),
        .cmd_data(cmd_data), .cmd_sel(cmd_sel), .red(red), .yellow(yellow),
        .green(green), .active_idx(active_idx), .override_active(override_active),
        .ped_pending(ped_pending)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycles the present lamp pattern persists; ends on the first sample of the next one
    task automatic measure(output int n);
        logic [8:0] pat;
        pat = lamps;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lamps == pat && n < 500);
    endtask

    task automatic phase(input string tag, input logic [8:0] pat, input int exp_len);
        int n;
        chk({tag, "_pat"}, 32'(lamps), 32'(pat));
        measure(n);
        chk({tag, "_len"}, 32'(n), 32'(exp_len));
    endtask

    task automatic send_cmd(input logic [7:0] d, input logic [1:0] s);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_sel   = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_ped(input logic [2:0] p);
        ped_req = p;
        @(negedge clk);
        ped_req = 3'b000;
    endtask

    // Each approach lights exactly one lamp and at most one approach is not red
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            logic ok;
            ok = ($countones(~red) <= 1);
            for (int i = 0; i < 3; i++) begin
                if ((32'(red[i]) + 32'(yellow[i]) + 32'(green[i])) != 1) ok = 1'b0;
            end
            chk("lamp_inv", 32'(ok), 32'd1);
        end
    end

    initial begin
        rst_n = 1'b0; ped_req = '0; cmd_valid = 1'b0; cmd_data = '0; cmd_sel = '0;
        repeat (3) @(negedge clk);
        chk("rst_lamps", 32'(lamps), 32'(P_AR));
        chk("rst_ovr", 32'(override_active), 32'd0);
        chk("rst_pend", 32'(ped_pending), 32'd0);
        chk("rst_idx", 32'(active_idx), 32'd2);
        rst_n = 1'b1;
        @(negedge clk);

        // Full unloaded rotation
        phase("ar_init", P_AR, 10);
        phase("g0", P_G0, 40);
        phase("y0", P_Y0, 20);
        phase("ar0", P_AR, 10);
        chk("idx_g1", 32'(active_idx), 32'd1);
        phase("g1", P_G1, 40);
        phase("y1", P_Y1, 20);
        phase("ar1", P_AR, 10);
        phase("g2", P_G2, 40);
        phase("y2", P_Y2, 20);
        phase("ar2", P_AR, 10);

        // One extension per green, other-approach press latched as pending
        chk("g0_ped_pat", 32'(lamps), 32'(P_G0));
        repeat (5) @(negedge clk);
        pulse_ped(3'b001);
        repeat (14) @(negedge clk);
        pulse_ped(3'b001);
        repeat (9) @(negedge clk);
        pulse_ped(3'b100);
        repeat (4) @(negedge clk);
        chk("pend_after_req", 32'(ped_pending), 32'b100);
        measure(len);
        chk("g0_ext_len", 32'(len + 35), 32'd70);
        phase("y0_b", P_Y0, 20);
        phase("ar0_b", P_AR, 10);
        chk("pend_in_g1", 32'(ped_pending), 32'b100);
        phase("g1_b", P_G1, 40);
        phase("y1_b", P_Y1, 20);
        phase("ar1_b", P_AR, 10);
        chk("pend_clr_g2", 32'(ped_pending), 32'b000);

        // Invalid or out-of-mode commands change nothing
        chk("g2_cmd_pat", 32'(lamps), 32'(P_G2));
        repeat (5) @(negedge clk);
        send_cmd(8'h51, 2'd0);
        chk("ovr_after_q", 32'(override_active), 32'd0);
        send_cmd(8'h47, 2'd3);
        chk("ovr_after_sel3", 32'(override_active), 32'd0);
        send_cmd(8'h58, 2'd1);
        chk("ovr_after_x", 32'(override_active), 32'd0);
        chk("idx_after_bad", 32'(active_idx), 32'd2);
        measure(len);
        chk("g2_cmd_len", 32'(len + 8), 32'd40);
        phase("y2_b", P_Y2, 20);
        phase("ar2_b", P_AR, 10);
        phase("g0_c", P_G0, 40);

        // Override during Y0, colour change, then release
        chk("y0_ovr_pat", 32'(lamps), 32'(P_Y0));
        repeat (5) @(negedge clk);
        send_cmd(8'h47, 2'd2);
        chk("ovr_set", 32'(override_active), 32'd1);
        chk("ovr_idx", 32'(active_idx), 32'd2);
        chk("ovr_lamp_lat", 32'(lamps), 32'(P_Y0));
        @(negedge clk);
        chk("ovr_g2", 32'(lamps), 32'(P_G2));
        repeat (210) @(negedge clk);
        chk("ovr_g2_hold", 32'(lamps), 32'(P_G2));
        chk("ovr_hold", 32'(override_active), 32'd1);
        send_cmd(8'h59, 2'd2);
        @(negedge clk);
        chk("ovr_y2", 32'(lamps), 32'(P_Y2));
        send_cmd(8'h58, 2'd2);
        chk("ovr_rel", 32'(override_active), 32'd0);
        @(negedge clk);
        chk("ovr_ar_pat", 32'(lamps), 32'(P_AR));
        measure(len);
        chk("ovr_ar_len", 32'(len >= 1 && len <= 10), 32'd1);
        phase("g0_after_x", P_G0, 40);
        phase("y0_d", P_Y0, 20);
        phase("ar0_d", P_AR, 10);
        phase("g1_d", P_G1, 40);

        // Asynchronous reset mid-Y1
        chk("y1_rst_pat", 32'(lamps), 32'(P_Y1));
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_lamps", 32'(lamps), 32'(P_AR));
        chk("async_rst_idx", 32'(active_idx), 32'd2);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        phase("ar_post_rst", P_AR, 10);
        chk("idx_post_rst", 32'(active_idx), 32'd0);
        phase("g0_post_rst", P_G0, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
